pipe_skid_stage: RTL and testbench

- Parametrised pipeline stage register, successor to the fixed 32-bit stall/flush stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, a one-entry skid buffer (so in_ready is registered and never combinationally depends on out_ready), a configurable bubble payload, and flush with defined priority.
- One instance carries a whole stage bundle, e.g. {PCplus4, Instruction} with WIDTH=64.

---
 rtl/pipe_skid_stage.sv | 117 +++++++++++
 tb/tb_pipe_skid_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with one-entry skid buffer and flush
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage #(
    parameter int unsigned           WIDTH      = 64,
    parameter logic [WIDTH-1:0]      BUBBLE_VAL = '0,
    parameter int unsigned           CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_SKID_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH < 1 || WIDTH > 256 || CNT_W < 1) begin : g_param_check
        $error("pipe_skid_stage: WIDTH must be 1..256 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs decode only from registered state, so neither depends on any input.
    assign out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_FULL);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A concurrent in_fire is swallowed; a concurrent out_fire has already been seen downstream.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating; only reset clears it so flushes do not hide stall history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed table and scoreboard stress bench for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam int unsigned      W      = 32;
    localparam logic [W-1:0]     BUBBLE = 32'h0000_DEAD;
    localparam int unsigned      CW     = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [CW-1:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_skid_stage #(
        .WIDTH      (W),
        .BUBBLE_VAL (BUBBLE),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic         e_ir;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t vecs[17];

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [W-1:0] sb[$];

    initial begin
        // streaming through the stage, one cycle of latency
        vecs[0]  = '{1'b1, 32'd1,  1'b1, 1'b0, 1'b1, 1'b1, 32'd1};
        vecs[1]  = '{1'b1, 32'd2,  1'b1, 1'b0, 1'b1, 1'b1, 32'd2};
        vecs[2]  = '{1'b1, 32'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'd3};
        vecs[3]  = '{1'b1, 32'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'd4};
        vecs[4]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'd4};
        // backpressure into the skid slot, then drain in order
        vecs[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA};
        vecs[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA};
        vecs[7]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB};
        // flush while both entries are live
        vecs[10] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11};
        vecs[11] = '{1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11};
        vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, BUBBLE};
        // flush with simultaneous in_fire and out_fire in FULL
        vecs[13] = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21};
        vecs[14] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, BUBBLE};
        vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, BUBBLE};
        vecs[16] = '{1'b1, 32'h31, 1'b1, 1'b0, 1'b1, 1'b1, 32'h31};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step_idle(3);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_data",  out_data, BUBBLE);
        reset = 1'b1;

        // mid-operation async reset discards a full skid
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step_idle(2);
        check("pre_reset_skid_in_ready", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("async_reset_out_data",  out_data, BUBBLE);
        step_idle(1);
        check("held_reset_in_ready", {31'd0, in_ready},  32'd1);
        check("held_reset_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        step_idle(1);

        for (int i = 0; i < 17; i++) begin
            if (i == 14) check("flush_pre_old_word_visible", out_data, 32'h21);
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d_out_data", i),  out_data, vecs[i].e_od);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step_idle(1);
        check("pre_stress_empty", {31'd0, out_valid}, 32'd0);

        // random stress against a scoreboard FIFO
        for (int c = 0; c < 10000; c++) begin
            int dens;
            logic ir_a;
            dens = (c / 1000) % 7 * 10 + 30;
            in_valid  = ($urandom_range(99) < dens);
            out_ready = ($urandom_range(99) < (120 - dens));
            in_data   = $urandom;
            #1;
            ir_a = in_ready;
            out_ready = ~out_ready;
            #1;
            if (in_ready !== ir_a) check("in_ready_indep_of_out_ready", {31'd0, in_ready}, {31'd0, ir_a});
            checks++;
            out_ready = ~out_ready;
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("stress_pop_on_empty_sb", {31'd0, out_valid}, 32'd0);
                else check("stress_order", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (out_valid) check("drain_order", out_data, sb.pop_front());
            @(posedge clk);
            #1;
        end
        check("drain_sb_empty", sb.size(), 32'd0);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_PERF_EN
        reset = 1'b0; #2 reset = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
        step_idle(1);
        in_valid = 1'b0;
        step_idle(20);
        check("stall_cnt_saturated", {28'd0, stall_cnt}, 32'd15);
        flush = 1'b1;
        step_idle(1);
        flush = 1'b0;
        check("stall_cnt_after_flush", {28'd0, stall_cnt}, 32'd15);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0; #1;
        check("stall_cnt_reset", {28'd0, stall_cnt}, 32'd0);
        reset = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
